generador_vga_timing: RTL and testbench
=======================================

# generador_vga_timing

Video timing generator for the oscilloscope display. It produces the pixel coordinates that the cursor bars and trace renderers compare against, plus the VGA sync signals. It runs from the board clock, with an optional integer pixel-clock divider. Its default timing is 1024x768@60 (65 MHz pixel clock), which matches the 11-bit coordinate buses used across the display path.

## Interface

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 160, horizontal back porch (pixels)
- V_VISIBLE, 768, active lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CLK_DIV, 1, clk_fpga cycles per pixel (≥1)

Ports:
- clk_fpga  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- hc_visible  out  11  horizontal pixel index in the active area, else 0
- vc_visible  out  11  vertical line index in the active area, else 0
- visible  out  1  high when the current position is in the active area
- hsync  out  1  horizontal sync, polarity set by HSYNC_POL
- vsync  out  1  vertical sync, polarity set by VSYNC_POL
- pix_tick  out  1  one-clk strobe marking the last cycle of each pixel
- frame_start  out  1  one-clk pulse on the first cycle of position (0,0)

## Operation

- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1344). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (806).
- Region order, per line and per frame: visible, front porch, sync, back porch.
- Divider counter div runs 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1).
  - With CLK_DIV=1, pix_tick is constantly high.
- Position counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) are 11 bits each and advance only on cycles where pix_tick is high:
  - hc < H_TOTAL-1: hc+1.
  - hc = H_TOTAL-1: hc←0 and vc advances.
  - vc advances as vc+1, or wraps to 0 when vc = V_TOTAL-1.
- Decode of the current (hc,vc):
  - visible = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - hc_visible = visible ? hc : 0.
  - vc_visible = visible ? vc : 0.
  - hsync is active while H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC, at any vc, porches included.
  - vsync is active while V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC, for the full width of those lines.
- frame_start is high for exactly one clk_fpga cycle: the first cycle in which (hc,vc)=(0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
- All outputs are registered. The registers load the decode of the next position, so outputs are always aligned with the position counters, with zero offset and no glitches.
- No other inputs; the block free-runs.

## Timing

- Reset (rst high at a clk_fpga edge):
  - Next cycle: div=0, hc=0, vc=0.
  - Outputs: visible=1, hc_visible=0, vc_visible=0, hsync and vsync inactive (1 with default polarity), frame_start=0.
  - pix_tick is 1 if CLK_DIV=1, else 0.
- Reset mid-frame or mid-pixel has the same effect: it abandons the current position and the divider phase in one cycle, and no frame_start is issued for that (0,0).
- Reset release: the first advance occurs on the cycle where pix_tick is high, i.e. after CLK_DIV cycles. Each position is held exactly CLK_DIV clk_fpga cycles.
- Line period: H_TOTAL·CLK_DIV cycles. Frame period: H_TOTAL·V_TOTAL·CLK_DIV cycles (1,083,264 at defaults).
- Simultaneous end-of-line and end-of-frame: hc and vc both wrap on the same pix_tick, and frame_start asserts on the following cycle.
- frame_start lasts one clk_fpga cycle even when CLK_DIV>1. It coincides with the first of the CLK_DIV cycles at (0,0).
- Coordinate consumers comparing against hc_visible must qualify with visible, because index 0 and blanking both read 0.

## Test plan

- Reset values: hold rst high for 3 cycles, then release with CLK_DIV=1.
  - → During reset: hc_visible=0, vc_visible=0, visible=1, hsync=1, vsync=1, frame_start=0.
  - → The cycle after release: hc_visible=1.
- Horizontal timing, line 0, defaults:
  - → visible falls at hc=1024.
  - → hsync=0 for hc 1048..1183 (136 cycles), otherwise 1.
  - → Line wraps after 1344 cycles, with vc_visible=1 at the next hc=0.
- Vertical and frame wrap:
  - → vsync=0 for lines 771..776 only.
  - → visible=0 on lines 768..805.
  - → At (1343,805) the next cycle is (0,0), with frame_start=1 for that one cycle.
  - → Exactly 1,083,264 cycles between frame_start pulses.
- CLK_DIV=3:
  - → pix_tick pattern 0,0,1 repeating.
  - → hc_visible holds each value for 3 cycles.
  - → hsync low width is 408 cycles.
  - → frame_start width is 1 cycle.
- Reset mid-frame at (500,400) with CLK_DIV=2, pulsed on the second cycle of a pixel:
  - → Next cycle: position (0,0), div=0, frame_start=0.
  - → Timing proceeds identically to a cold reset.
- Non-default polarity, HSYNC_POL=1 and VSYNC_POL=1:
  - → Sync pulses are high over the same intervals as above.
  - → Reset level of hsync and vsync is 0.

Source files
------------

// File: rtl/generador_vga_timing.sv
// Free-running VGA timing generator: pixel coordinates, blanking and sync for the scope display.
// Every output is registered from the decode of the next position, so it stays aligned with hc/vc.
module generador_vga_timing #(
  parameter int   H_VISIBLE = 1024,
  parameter int   H_FRONT   = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BACK    = 160,
  parameter int   V_VISIBLE = 768,
  parameter int   V_FRONT   = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BACK    = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CLK_DIV   = 1
) (
  input  logic        clk_fpga,
  input  logic        rst,
  output logic [10:0] hc_visible,
  output logic [10:0] vc_visible,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_tick,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Output levels for position (0,0) with the divider at phase 0.
  localparam logic RST_VISIBLE = (H_VISIBLE > 0) && (V_VISIBLE > 0);
  localparam logic RST_TICK    = (CLK_DIV == 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [10:0]      hc_reg, hc_next;
  logic [10:0]      vc_reg, vc_next;
  logic             frame_wrap_next;
  logic             visible_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             pix_tick_next;

  always_comb begin
    div_next        = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    hc_next         = hc_reg;
    vc_next         = vc_reg;
    frame_wrap_next = 1'b0;
    if (div_reg == DIV_LAST) begin
      if (hc_reg == H_LAST) begin
        hc_next = '0;
        if (vc_reg == V_LAST) begin
          vc_next         = '0;
          frame_wrap_next = 1'b1;
        end else begin
          vc_next = vc_reg + 11'd1;
        end
      end else begin
        hc_next = hc_reg + 11'd1;
      end
    end
  end

  assign visible_next  = (hc_next < H_VIS_END) && (vc_next < V_VIS_END);
  assign hsync_next    = ((hc_next >= H_SYNC_BEG) && (hc_next < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_next    = ((vc_next >= V_SYNC_BEG) && (vc_next < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
  assign pix_tick_next = (div_next == DIV_LAST);

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      div_reg     <= '0;
      hc_reg      <= '0;
      vc_reg      <= '0;
      visible     <= RST_VISIBLE;
      hc_visible  <= '0;
      vc_visible  <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      pix_tick    <= RST_TICK;
      frame_start <= 1'b0;
    end else begin
      div_reg     <= div_next;
      hc_reg      <= hc_next;
      vc_reg      <= vc_next;
      visible     <= visible_next;
      hc_visible  <= visible_next ? hc_next : 11'd0;
      vc_visible  <= visible_next ? vc_next : 11'd0;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      pix_tick    <= pix_tick_next;
      // Only a real wrap from the last position starts a frame; reset to (0,0) does not.
      frame_start <= frame_wrap_next && (div_reg == DIV_LAST);
    end
  end
endmodule

// File: tb/tb_generador_vga_timing.sv
// Self-checking bench: four timing generators (default and reduced geometries, several dividers
// and polarities) checked every cycle against an arithmetic model of elapsed cycles since reset.
module tb_generador_vga_timing;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults. 1: small, div 1. 2: small, div 2. 3: small, div 3, positive syncs.
  logic        rst [4];
  logic [10:0] hv  [4];
  logic [10:0] vv  [4];
  logic        vis [4];
  logic        hs  [4];
  logic        vs  [4];
  logic        pt  [4];
  logic        fs  [4];
  int          n   [4];

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [10:0] hv;
    logic [10:0] vv;
    logic        vis;
    logic        hs;
    logic        vs;
    logic        pt;
    logic        fs;
  } obs_t;

  generador_vga_timing u_def (
    .clk_fpga(clk), .rst(rst[0]), .hc_visible(hv[0]), .vc_visible(vv[0]), .visible(vis[0]),
    .hsync(hs[0]), .vsync(vs[0]), .pix_tick(pt[0]), .frame_start(fs[0]));

  generador_vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
  ) u_s1 (
    .clk_fpga(clk), .rst(rst[1]), .hc_visible(hv[1]), .vc_visible(vv[1]), .visible(vis[1]),
    .hsync(hs[1]), .vsync(vs[1]), .pix_tick(pt[1]), .frame_start(fs[1]));

  generador_vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
  ) u_s2 (
    .clk_fpga(clk), .rst(rst[2]), .hc_visible(hv[2]), .vc_visible(vv[2]), .visible(vis[2]),
    .hsync(hs[2]), .vsync(vs[2]), .pix_tick(pt[2]), .frame_start(fs[2]));

  generador_vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(3)
  ) u_s3 (
    .clk_fpga(clk), .rst(rst[3]), .hc_visible(hv[3]), .vc_visible(vv[3]), .visible(vis[3]),
    .hsync(hs[3]), .vsync(vs[3]), .pix_tick(pt[3]), .frame_start(fs[3]));

  // Cycles elapsed since the last reset edge of each instance.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) n[i] <= rst[i] ? 0 : n[i] + 1;
  end

  // Expected outputs after nn cycles: position = floor(nn / div) along a raster of ht*vt pixels.
  function automatic obs_t model(input int idx, input int nn);
    obs_t r;
    int hvis, hf, hsw, hb, vvis, vf, vsw, vb, d, ht, vt, p, h, v;
    logic pol;
    if (idx == 0) begin
      hvis = 1024; hf = 24; hsw = 136; hb = 160; vvis = 768; vf = 3; vsw = 6; vb = 29;
    end else begin
      hvis = 16; hf = 2; hsw = 3; hb = 3; vvis = 8; vf = 1; vsw = 2; vb = 2;
    end
    d   = (idx == 2) ? 2 : (idx == 3) ? 3 : 1;
    pol = (idx == 3);
    ht  = hvis + hf + hsw + hb;
    vt  = vvis + vf + vsw + vb;
    p   = (nn / d) % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    r.vis = (h < hvis) && (v < vvis);
    r.hv  = r.vis ? 11'(h) : 11'd0;
    r.vv  = r.vis ? 11'(v) : 11'd0;
    r.hs  = (h >= hvis + hf && h < hvis + hf + hsw) ? pol : ~pol;
    r.vs  = (v >= vvis + vf && v < vvis + vf + vsw) ? pol : ~pol;
    r.pt  = (nn % d) == d - 1;
    r.fs  = (nn > 0) && (nn % (ht * vt * d) == 0);
    return r;
  endfunction

  function automatic obs_t got(input int i);
    return {hv[i], vv[i], vis[i], hs[i], vs[i], pt[i], fs[i]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all();
    obs_t g, e;
    for (int i = 0; i < 4; i++) begin
      g = got(i);
      e = model(i, n[i]);
      total_cnt++;
      if (g == e) pass_cnt++;
      else $display("FAIL model inst%0d n=%0d: got hv=%0d vv=%0d vis=%b hs=%b vs=%b pt=%b fs=%b expected hv=%0d vv=%0d vis=%b hs=%b vs=%b pt=%b fs=%b",
                    i, n[i], g.hv, g.vv, g.vis, g.hs, g.vs, g.pt, g.fs,
                    e.hv, e.vv, e.vis, e.hs, e.vs, e.pt, e.fs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int   n;
    logic vis;
    logic hs;
    int   hv;
    int   vv;
  } hvec_t;

  hvec_t tbl[10];

  initial begin
    int guard, cnt, held, pick;

    tbl[0] = '{0,    1'b1, 1'b1, 0,    0};
    tbl[1] = '{1023, 1'b1, 1'b1, 1023, 0};
    tbl[2] = '{1024, 1'b0, 1'b1, 0,    0};
    tbl[3] = '{1047, 1'b0, 1'b1, 0,    0};
    tbl[4] = '{1048, 1'b0, 1'b0, 0,    0};
    tbl[5] = '{1183, 1'b0, 1'b0, 0,    0};
    tbl[6] = '{1184, 1'b0, 1'b1, 0,    0};
    tbl[7] = '{1343, 1'b0, 1'b1, 0,    0};
    tbl[8] = '{1344, 1'b1, 1'b1, 0,    1};
    tbl[9] = '{1345, 1'b1, 1'b1, 1,    1};

    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("rst_hv", hv[1], 0);
    chk("rst_vv", vv[1], 0);
    chk("rst_vis", vis[1], 1);
    chk("rst_hs", hs[1], 1);
    chk("rst_vs", vs[1], 1);
    chk("rst_fs", fs[1], 0);
    chk("rst_hs_pol1", hs[3], 0);
    chk("rst_vs_pol1", vs[3], 0);
    chk("rst_pt_div3", pt[3], 0);

    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    chk("tbl_start_hv", hv[0], 0);
    step();
    chk("release_hv_def", hv[0], 1);
    chk("release_hv_s1", hv[1], 1);

    // Horizontal timing of line 0 at default geometry.
    for (int k = 0; k < 10; k++) begin
      if (tbl[k].n == 0) continue;
      guard = 0;
      while (n[0] < tbl[k].n && guard < 2000) begin step(); guard++; end
      chk($sformatf("tbl%0d_reach", k), n[0], tbl[k].n);
      chk($sformatf("tbl%0d_vis", k), vis[0], tbl[k].vis);
      chk($sformatf("tbl%0d_hs", k), hs[0], tbl[k].hs);
      chk($sformatf("tbl%0d_hv", k), hv[0], tbl[k].hv);
      chk($sformatf("tbl%0d_vv", k), vv[0], tbl[k].vv);
    end

    // Divide-by-3: tick pattern 0,0,1 and each coordinate held three cycles.
    guard = 0;
    while (!(pt[3] && vis[3]) && guard < 200) begin step(); guard++; end
    chk("div3_sync_tick", pt[3], 1);
    step();
    held = hv[3];
    chk("div3_pt0", pt[3], 0);
    step();
    chk("div3_pt1", pt[3], 0);
    chk("div3_hold1", hv[3], held);
    step();
    chk("div3_pt2", pt[3], 1);
    chk("div3_hold2", hv[3], held);

    // Positive hsync width on the div-3 instance: 3 pixels * 3 cycles.
    guard = 0;
    while (hs[3] && guard < 200) begin step(); guard++; end
    while (!hs[3] && guard < 200) begin step(); guard++; end
    cnt = 0;
    while (hs[3] && cnt < 200) begin step(); cnt++; end
    chk("div3_hsync_width", cnt, 9);

    // Frame period with div 1.
    guard = 0;
    while (!fs[1] && guard < 400) begin step(); guard++; end
    chk("s1_fs_seen", fs[1], 1);
    cnt = 0;
    do begin step(); cnt++; end while (!fs[1] && cnt < 400);
    chk("s1_frame_period", cnt, 312);

    // Frame pulse width and period with div 3.
    guard = 0;
    while (!fs[3] && guard < 1000) begin step(); guard++; end
    chk("s3_fs_seen", fs[3], 1);
    step();
    chk("s3_fs_width", fs[3], 0);
    cnt = 1;
    while (!fs[3] && cnt < 1000) begin step(); cnt++; end
    chk("s3_frame_period", cnt, 936);

    // Reset of the div-2 instance on the second cycle of pixel (10,5).
    guard = 0;
    while (!(hv[2] == 11'd10 && vv[2] == 11'd5 && vis[2] && pt[2]) && guard < 700) begin
      step(); guard++;
    end
    chk("s2_reach_10_5", hv[2], 10);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    chk("s2_mid_hv", hv[2], 0);
    chk("s2_mid_vv", vv[2], 0);
    chk("s2_mid_vis", vis[2], 1);
    chk("s2_mid_pt", pt[2], 0);
    chk("s2_mid_fs", fs[2], 0);
    step();
    chk("s2_after_pt", pt[2], 1);
    chk("s2_after_hv0", hv[2], 0);
    step();
    chk("s2_after_hv1", hv[2], 1);
    chk("s2_after_fs", fs[2], 0);

    // Random reset pulses on the reduced instances; the per-cycle model checks everything.
    for (int r = 0; r < 20; r++) begin
      cnt = $urandom_range(5, 200);
      for (int k = 0; k < cnt; k++) step();
      pick = $urandom_range(1, 3);
      rst[pick] = 1'b1;
      cnt = $urandom_range(1, 3);
      for (int k = 0; k < cnt; k++) step();
      rst[pick] = 1'b0;
    end
    for (int k = 0; k < 1000; k++) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
